// File: rtl/step_feedback_meter_if.sv
// Signal bundle between the step feedback source (master) and the step_feedback_meter (slave).
// Carries the conditioned-input side of the step line and the measurement results.
interface step_feedback_meter_if #(
  parameter int SIZE  = 16,
  parameter int POS_W = 32
);
  logic             enable;
  logic             step_in;
  logic             dir_in;
  logic             clr_pos;
  logic [SIZE-1:0]  period;
  logic             period_valid;
  logic [POS_W-1:0] position;
  logic             stalled;

  modport master (
    output enable, step_in, dir_in, clr_pos,
    input  period, period_valid, position, stalled
  );

  modport slave (
    input  enable, step_in, dir_in, clr_pos,
    output period, period_valid, position, stalled
  );
endinterface

// File: rtl/step_feedback_meter.sv
// Receive side of the stepper step interface: measures the step period, tracks a signed
// position from the direction line and flags a stalled motor when steps stop arriving.
module step_feedback_meter #(
  parameter int SIZE    = 16,
  parameter int POS_W   = 32,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  step_feedback_meter_if.slave bus
);

  localparam logic [3:0]       FILT_LAST   = 4'(FILTER - 1);
  localparam logic [SIZE-1:0]  CNT_MAX     = '1;
  localparam logic [SIZE-1:0]  CNT_ONE     = SIZE'(1);
  localparam logic [SIZE-1:0]  TIMEOUT_CNT = SIZE'(TIMEOUT);
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_STALLED
  } meter_state_e;

  meter_state_e     state_q, state_d;

  logic             step_meta_q, step_meta_d;
  logic             step_sync_q, step_sync_d;
  logic             dir_meta_q, dir_meta_d;
  logic             dir_sync_q, dir_sync_d;

  logic             filt_q, filt_d;
  logic [3:0]       stab_cnt_q, stab_cnt_d;
  logic             step_event;

  logic [SIZE-1:0]  p_cnt_q, p_cnt_d;
  logic [SIZE-1:0]  period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic [POS_W-1:0] position_q, position_d;

  // Two-flop synchronizers; the filter below only ever sees the second stage.
  always_comb begin
    step_meta_d = bus.step_in;
    step_sync_d = step_meta_q;
    dir_meta_d  = bus.dir_in;
    dir_sync_d  = dir_meta_q;
  end

  // A level change is accepted on the FILTER-th consecutive differing sample.
  always_comb begin
    filt_d     = filt_q;
    stab_cnt_d = '0;
    step_event = 1'b0;
    if (step_sync_q != filt_q) begin
      if (stab_cnt_q == FILT_LAST) begin
        filt_d     = step_sync_q;
        step_event = step_sync_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    p_cnt_d        = p_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      p_cnt_d = '0;
    end else if (step_event) begin
      p_cnt_d = CNT_ONE;
      if (state_q == ST_ARMED) begin
        period_d       = p_cnt_q;
        period_valid_d = 1'b1;
      end else begin
        state_d = ST_ARMED;
      end
    end else begin
      if (p_cnt_q != CNT_MAX) begin
        p_cnt_d = p_cnt_q + CNT_ONE;
      end
      // An event landing on the timeout cycle is taken by the branch above instead.
      if (state_q == ST_ARMED && p_cnt_q == TIMEOUT_CNT) begin
        state_d = ST_STALLED;
      end
    end
  end

  always_comb begin
    position_d = position_q;
    if (bus.clr_pos) begin
      position_d = '0;
    end else if (bus.enable && step_event) begin
      position_d = dir_sync_q ? position_q + POS_ONE : position_q - POS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_meta_q    <= 1'b0;
      step_sync_q    <= 1'b0;
      dir_meta_q     <= 1'b0;
      dir_sync_q     <= 1'b0;
      filt_q         <= 1'b0;
      stab_cnt_q     <= '0;
      state_q        <= ST_IDLE;
      p_cnt_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      position_q     <= '0;
    end else begin
      step_meta_q    <= step_meta_d;
      step_sync_q    <= step_sync_d;
      dir_meta_q     <= dir_meta_d;
      dir_sync_q     <= dir_sync_d;
      filt_q         <= filt_d;
      stab_cnt_q     <= stab_cnt_d;
      state_q        <= state_d;
      p_cnt_q        <= p_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      position_q     <= position_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.position     = position_q;
  assign bus.stalled      = (state_q == ST_STALLED);

endmodule

// File: tb/tb_step_feedback_meter.sv
// Directed bench for step_feedback_meter: a timestamp-based reference model is compared every
// cycle, and hand-computed literals pin both the DUT and the model at each scenario.
module tb_step_feedback_meter;

  localparam int SIZE    = 16;
  localparam int POS_W   = 32;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 1000;

  logic clk;
  logic rst;
  logic en;
  logic step;
  logic dir;
  logic clr;

  int vectors;
  int miscompares;
  int pv_total;
  int pv0;
  bit chk_en;

  step_feedback_meter_if #(.SIZE(SIZE), .POS_W(POS_W)) bus ();
  step_feedback_meter_if #(.SIZE(SIZE), .POS_W(8))     bus8 ();

  assign bus.enable   = en;
  assign bus.step_in  = step;
  assign bus.dir_in   = dir;
  assign bus.clr_pos  = clr;
  assign bus8.enable  = en;
  assign bus8.step_in = step;
  assign bus8.dir_in  = dir;
  assign bus8.clr_pos = clr;

  step_feedback_meter #(.SIZE(SIZE), .POS_W(POS_W), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  step_feedback_meter #(.SIZE(SIZE), .POS_W(8), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: events come from a window over the raw sample history, periods from
  // event timestamps, stall from the time since the last arming/measured event.
  logic [7:0]       sh;
  logic [7:0]       dh;
  logic             m_filt;
  logic             m_ev;
  logic             m_armed;
  logic             m_stalled;
  logic [SIZE-1:0]  m_period;
  logic             m_pv;
  logic [POS_W-1:0] m_pos;
  int               cyc;
  int               last_ev;
  bit               all_diff;

  initial begin
    sh = '0; dh = '0; m_filt = 0; m_ev = 0; m_armed = 0; m_stalled = 0;
    m_period = '0; m_pv = 0; m_pos = '0; cyc = 0; last_ev = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        sh = '0; dh = '0; m_filt = 0; m_armed = 0; m_stalled = 0;
        m_period = '0; m_pv = 0; m_pos = '0; cyc = 0; last_ev = 0;
      end else begin
        cyc++;
        sh = {sh[6:0], step};
        dh = {dh[6:0], dir};
        all_diff = 1;
        for (int i = 2; i < FILTER + 2; i++) if (sh[i] == m_filt) all_diff = 0;
        m_ev = 0;
        if (all_diff) begin
          m_filt = ~m_filt;
          m_ev   = m_filt;
        end
        m_pv = 0;
        if (!en) begin
          m_armed   = 0;
          m_stalled = 0;
        end else if (m_ev) begin
          if (m_armed) begin
            m_period = SIZE'(cyc - last_ev);
            m_pv     = 1;
          end else begin
            m_armed   = 1;
            m_stalled = 0;
          end
          last_ev = cyc;
          if (!clr) m_pos = dh[2] ? m_pos + 32'd1 : m_pos - 32'd1;
        end else if (m_armed && (cyc - last_ev) == TIMEOUT) begin
          m_stalled = 1;
          m_armed   = 0;
        end
        if (clr) m_pos = '0;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (bus.period_valid === 1'b1) pv_total++;
        check_output("period",       64'(bus.period),       64'(m_period));
        check_output("period_valid", 64'(bus.period_valid), 64'(m_pv));
        check_output("position",     64'(bus.position),     64'(m_pos));
        check_output("stalled",      64'(bus.stalled),      64'(m_stalled));
        check_output("position8",    64'(bus8.position),    64'(m_pos[7:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_pulse(input int high, input int low);
    step = 1'b1;
    tick(high);
    step = 1'b0;
    tick(low);
  endtask

  initial begin
    vectors = 0; miscompares = 0; pv_total = 0; chk_en = 0;
    rst = 1'b1; en = 1'b0; step = 1'b0; dir = 1'b1; clr = 1'b0;
    #1 rst = 1'b0;
    chk_en = 1;
    tick(3);
    check_output("rst_period",   64'(bus.period), 0);
    check_output("rst_pv",       64'(bus.period_valid), 0);
    check_output("rst_position", 64'(bus.position), 0);
    check_output("rst_stalled",  64'(bus.stalled), 0);
    rst = 1'b1;
    en  = 1'b1;
    tick(5);

    // Five 10/90 pulses: first event arms only, then four periods of 100.
    $display("[TB] pulse train 10/90");
    pv0 = pv_total;
    step = 1'b1;
    tick(5);
    check_output("lat_before_event", 64'(bus.position), 0);
    tick(1);
    check_output("lat_event", 64'(bus.position), 1);
    tick(4);
    step = 1'b0;
    tick(90);
    repeat (4) apply_pulse(10, 90);
    check_output("train_pv_count", 64'(pv_total - pv0), 4);
    check_output("train_period",   64'(bus.period), 100);
    check_output("train_position", 64'(bus.position), 5);
    check_output("model_train_period", 64'(m_period), 100);
    check_output("model_train_pos",    64'(m_pos), 5);

    $display("[TB] glitch filter");
    pv0 = pv_total;
    apply_pulse(3, 20);
    check_output("glitch_position", 64'(bus.position), 5);
    check_output("glitch_pv_count", 64'(pv_total - pv0), 0);
    apply_pulse(4, 20);
    check_output("short_pulse_position", 64'(bus.position), 6);
    check_output("short_pulse_pv_count", 64'(pv_total - pv0), 1);
    check_output("short_pulse_period",   64'(bus.period), 123);

    $display("[TB] direction and clear");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_output("clr_position", 64'(bus.position), 0);
    dir = 1'b1;
    repeat (3) apply_pulse(10, 40);
    dir = 1'b0;
    repeat (5) apply_pulse(10, 40);
    check_output("dir_position",  64'(bus.position), 64'h0000_0000_FFFF_FFFE);
    check_output("dir_position8", 64'(bus8.position), 64'hFE);
    step = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_output("clr_event_position", 64'(bus.position), 0);
    check_output("clr_event_pv",       64'(bus.period_valid), 1);
    check_output("clr_event_period",   64'(bus.period), 50);

    $display("[TB] stall");
    tick(3);
    step = 1'b0;
    pv0 = pv_total;
    tick(996);
    check_output("stall_before", 64'(bus.stalled), 0);
    tick(1);
    check_output("stall_at_timeout", 64'(bus.stalled), 1);
    check_output("stall_pv_count",   64'(pv_total - pv0), 0);
    dir = 1'b1;
    pv0 = pv_total;
    step = 1'b1;
    tick(6);
    check_output("stall_cleared", 64'(bus.stalled), 0);
    tick(4);
    step = 1'b0;
    tick(190);
    step = 1'b1;
    tick(6);
    check_output("rearm_pv_count", 64'(pv_total - pv0), 0);
    check_output("rearm_pv",       64'(bus.period_valid), 1);
    check_output("rearm_period",   64'(bus.period), 200);

    $display("[TB] event on timeout cycle");
    tick(4);
    step = 1'b0;
    tick(990);
    step = 1'b1;
    tick(6);
    check_output("boundary_pv",      64'(bus.period_valid), 1);
    check_output("boundary_period",  64'(bus.period), 1000);
    check_output("boundary_stalled", 64'(bus.stalled), 0);
    check_output("model_boundary_period", 64'(m_period), 1000);
    tick(4);
    step = 1'b0;
    tick(10);

    $display("[TB] position wrap");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    repeat (127) apply_pulse(5, 5);
    check_output("wrap_pos8_7f", 64'(bus8.position), 64'h7F);
    check_output("wrap_pos_7f",  64'(bus.position), 127);
    apply_pulse(5, 5);
    check_output("wrap_pos8_80", 64'(bus8.position), 64'h80);
    check_output("wrap_pos_80",  64'(bus.position), 128);

    $display("[TB] async reset mid-filter");
    step = 1'b1;
    tick(2);
    #2 rst = 1'b0;
    #1;
    check_output("arst_period",   64'(bus.period), 0);
    check_output("arst_pv",       64'(bus.period_valid), 0);
    check_output("arst_position", 64'(bus.position), 0);
    check_output("arst_stalled",  64'(bus.stalled), 0);
    tick(3);
    rst = 1'b1;
    pv0 = pv_total;
    tick(10);
    check_output("arst_arm_position", 64'(bus.position), 1);
    check_output("arst_arm_pv_count", 64'(pv_total - pv0), 0);
    step = 1'b0;
    tick(40);
    repeat (2) apply_pulse(10, 40);
    check_output("arst_period_after", 64'(bus.period), 50);
    check_output("arst_position_after", 64'(bus.position), 3);

    $display("[TB] enable toggle");
    step = 1'b1;
    tick(2);
    en = 1'b0;
    tick(8);
    step = 1'b0;
    tick(20);
    check_output("dis_period_hold",   64'(bus.period), 50);
    check_output("dis_position_hold", 64'(bus.position), 3);
    check_output("dis_stalled",       64'(bus.stalled), 0);
    en = 1'b1;
    tick(20);
    pv0 = pv_total;
    step = 1'b1;
    tick(10);
    check_output("en_arm_position", 64'(bus.position), 4);
    check_output("en_arm_pv_count", 64'(pv_total - pv0), 0);
    step = 1'b0;
    tick(40);
    step = 1'b1;
    tick(6);
    check_output("en_period_pv", 64'(bus.period_valid), 1);
    check_output("en_period",    64'(bus.period), 50);
    tick(4);
    step = 1'b0;
    tick(20);
    check_output("en_final_position", 64'(bus.position), 5);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
